ra_pq_p: RTL and testbench
==========================

Name: ra_pq_p

Overview:
Parametrised register-array priority queue. It is the successor of the single-operation replace/deq register-array PQ. It adds explicit enqueue, full/count status, min- or max-first ordering and error flagging, while keeping the one-operation-per-cycle sorted-shift architecture. It sits between a scheduler front end and the HWPQ comparison harness, and is packed as {key,val} in the same way as the existing PQ interfaces.

Parameters:
KEY_WIDTH, 8, key bits; the priority field.
VAL_WIDTH, 8, payload bits carried with the key.
DEPTH, 8, number of slots; must be >= 2.
MIN_FIRST, 1, 1 = smallest key at head; 0 = largest key at head.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
enq  in  1  insert kvi.
deq  in  1  remove the head entry.
replace  in  1  remove the head and insert kvi in the same cycle.
kvi  in  KEY_WIDTH+VAL_WIDTH  input entry {key,val}; key in the MSBs.
kvo  out  KEY_WIDTH+VAL_WIDTH  head entry {key,val}; registered.
ovalid  out  1  kvo holds a valid entry; equals !empty.
empty  out  1  count == 0.
full  out  1  count == DEPTH.
count  out  $clog2(DEPTH+1)  number of stored entries.
err  out  1  one-cycle pulse when an illegal operation is dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All slot valid bits cleared; count=0, empty=1, full=0, ovalid=0, err=0.
  - kvo=0; slot data=0.
  - Reset asserted mid-operation discards that operation. Exit from reset is synchronous to clk.
- Storage:
  - Slots 0..DEPTH-1, each holding {valid,key,val}. Slot 0 is the head and drives kvo directly.
  - Valid slots form a contiguous prefix, kept sorted: each slot's key is better than or equal to the next slot's key. "Better" means smaller when MIN_FIRST=1, larger when MIN_FIRST=0.
  - Comparison is unsigned on the key only; val is never compared.
- Tie rule: a new entry is placed after all stored entries with an equal key, so equal keys dequeue in FIFO order.
- Operation decode, evaluated each cycle; exactly one effective operation per cycle:
  - replace=1, or enq=1 with deq=1 -> REPLACE (the enq+deq pair is treated as replace).
  - enq only -> ENQ.
  - deq only -> DEQ.
  - None asserted -> hold.
- ENQ:
  - Each slot i compares kvi against its own entry and takes one of: keep, load kvi, or shift from slot i-1.
  - count+1.
  - When full, the operation is dropped: no state change, err=1 next cycle.
- DEQ:
  - Slot i loads slot i+1; slot DEPTH-1 is invalidated. count-1.
  - When empty, the operation is dropped: err=1 next cycle.
- REPLACE:
  - Removes the head and inserts kvi at its sorted position among the remaining entries; count unchanged.
  - Legal when full.
  - When empty, behaves as ENQ (count becomes 1, no err).
- Latency:
  - Every output is registered and reflects an operation on the cycle after it is sampled.
  - Back-to-back operations are accepted on every cycle; there is no ready/stall.
- err:
  - Asserted for exactly one cycle per dropped operation, then cleared.
  - Never asserted for a legal operation.
- When empty, kvo holds its last value but ovalid=0; consumers must qualify kvo with ovalid.
- count, empty and full are always mutually consistent in the same cycle.

Test Plan:
- Reset then ordered inserts (DEPTH=4, MIN_FIRST=1):
  - Stimulus: rst_n low, release; enq (8,14),(11,11),(9,9),(10,10) on consecutive cycles.
  - Response: after the 1st enq kvo=(8,14); after the 4th, count=4, full=1, kvo=(8,14).
  - Successive deqs return keys 8,9,10,11.
- Replace and overflow (full queue from the previous scenario):
  - Stimulus: replace (1,1).
  - Response: kvo=(1,1), count=4.
  - Stimulus: enq (5,5).
  - Response: err pulses once, contents unchanged.
  - Stimulus: 4 deqs.
  - Response: keys 1,9,10,11 returned, then empty=1, ovalid=0.
- Underflow and empty-replace:
  - Stimulus: deq while empty.
  - Response: err=1 for one cycle, count stays 0.
  - Stimulus: replace (23,23) while empty.
  - Response: count=1, kvo=(23,23), err=0.
- Simultaneous enq+deq and ties (queue holds (17,25),(23,23)):
  - Stimulus: enq=deq=1 with kvi=(17,3).
  - Response: treated as replace; count stays 2; deq sequence returns (17,3) then (23,23).
  - Stimulus: enq (23,7).
  - Response: (23,7) dequeues after the existing (23,23) (FIFO tie order).
- Max mode (MIN_FIRST=0):
  - Stimulus: enq 3,200,50.
  - Response: deq order 200,50,3.
- Async reset mid-stream:
  - Stimulus: drop rst_n between clock edges while count=3.
  - Response: count=0, empty=1 and ovalid=0 immediately, without waiting for an edge; the next enq after release gives count=1.

Source files
------------

// File: rtl/ra_pq_p.sv
// Purpose: sorted register-array priority queue with enq/deq/replace, min- or max-first order.
// Latency: one cycle; every output is registered and shows an operation the cycle after it is sampled.
// Backpressure: none; one operation per cycle is always accepted, and an illegal one is dropped with an err pulse.
module ra_pq_p #(
  parameter int KEY_WIDTH = 8,
  parameter int VAL_WIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int MIN_FIRST = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enq,
  input  logic                              deq,
  input  logic                              replace,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0]    kvi,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0]    kvo,
  output logic                              ovalid,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              err
);

  localparam int KVW = KEY_WIDTH + VAL_WIDTH;
  localparam int CW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {OP_HOLD, OP_ENQ, OP_DEQ, OP_REPL} op_e;

  // Slot storage; slot 0 is the head.
  logic                 r_vld [DEPTH];
  logic [KEY_WIDTH-1:0] r_key [DEPTH];
  logic [VAL_WIDTH-1:0] r_val [DEPTH];
  logic [CW-1:0]        r_cnt;
  logic [KVW-1:0]       r_kvo;
  logic                 r_err;

  // Base view (current slots, or slots shifted up by one when the head leaves).
  logic                 w_b_vld [DEPTH];
  logic [KEY_WIDTH-1:0] w_b_key [DEPTH];
  logic [VAL_WIDTH-1:0] w_b_val [DEPTH];
  logic                 w_ins   [DEPTH];
  logic                 w_n_vld [DEPTH];
  logic [KEY_WIDTH-1:0] w_n_key [DEPTH];
  logic [VAL_WIDTH-1:0] w_n_val [DEPTH];
  logic [CW-1:0]        w_n_cnt;
  logic [KEY_WIDTH-1:0] w_key_in;
  logic [VAL_WIDTH-1:0] w_val_in;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_drop;
  op_e                  w_op;

  assign w_key_in = kvi[KVW-1:VAL_WIDTH];
  assign w_val_in = kvi[VAL_WIDTH-1:0];
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CW'(DEPTH));

  // Strict ordering: a new key only goes ahead of an entry it beats, so equal keys stay FIFO.
  function automatic logic f_better(input logic [KEY_WIDTH-1:0] a, input logic [KEY_WIDTH-1:0] b);
    return (MIN_FIRST != 0) ? (a < b) : (a > b);
  endfunction

  // Decode the single effective operation; enq+deq together is a replace.
  always_comb begin
    w_op = OP_HOLD;
    if (replace || (enq && deq)) w_op = OP_REPL;
    else if (enq)                w_op = OP_ENQ;
    else if (deq)                w_op = OP_DEQ;
    w_drop = ((w_op == OP_ENQ) && w_full) || ((w_op == OP_DEQ) && w_empty);
  end

  // Build the base view and mark every slot the new entry would sit at or before.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_b_vld[i] = r_vld[i];
      w_b_key[i] = r_key[i];
      w_b_val[i] = r_val[i];
    end
    if ((w_op == OP_DEQ) || (w_op == OP_REPL)) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        w_b_vld[i] = r_vld[i+1];
        w_b_key[i] = r_key[i+1];
        w_b_val[i] = r_val[i+1];
      end
      w_b_vld[DEPTH-1] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_ins[i] = !w_b_vld[i] || f_better(w_key_in, w_b_key[i]);
    end
  end

  // Per-slot next state: keep, load kvi at the insertion point, or shift from the slot above.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_n_vld[i] = r_vld[i];
      w_n_key[i] = r_key[i];
      w_n_val[i] = r_val[i];
    end
    if ((w_op == OP_DEQ) && !w_empty) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_n_vld[i] = w_b_vld[i];
        w_n_key[i] = w_b_key[i];
        w_n_val[i] = w_b_val[i];
      end
    end else if (((w_op == OP_ENQ) && !w_full) || (w_op == OP_REPL)) begin
      if (w_ins[0]) begin
        w_n_vld[0] = 1'b1;
        w_n_key[0] = w_key_in;
        w_n_val[0] = w_val_in;
      end else begin
        w_n_vld[0] = w_b_vld[0];
        w_n_key[0] = w_b_key[0];
        w_n_val[0] = w_b_val[0];
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_ins[i-1]) begin
          w_n_vld[i] = w_b_vld[i-1];
          w_n_key[i] = w_b_key[i-1];
          w_n_val[i] = w_b_val[i-1];
        end else if (w_ins[i]) begin
          w_n_vld[i] = 1'b1;
          w_n_key[i] = w_key_in;
          w_n_val[i] = w_val_in;
        end else begin
          w_n_vld[i] = w_b_vld[i];
          w_n_key[i] = w_b_key[i];
          w_n_val[i] = w_b_val[i];
        end
      end
    end
  end

  // Next occupancy; a replace on an empty queue acts as a plain insert.
  always_comb begin
    w_n_cnt = r_cnt;
    case (w_op)
      OP_ENQ:  if (!w_full)  w_n_cnt = r_cnt + CW'(1);
      OP_DEQ:  if (!w_empty) w_n_cnt = r_cnt - CW'(1);
      OP_REPL: if (w_empty)  w_n_cnt = CW'(1);
      default: w_n_cnt = r_cnt;
    endcase
  end

  // State update; kvo follows the head only while the head is valid, otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i] <= 1'b0;
        r_key[i] <= '0;
        r_val[i] <= '0;
      end
      r_cnt <= '0;
      r_kvo <= '0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i] <= w_n_vld[i];
        r_key[i] <= w_n_key[i];
        r_val[i] <= w_n_val[i];
      end
      r_cnt <= w_n_cnt;
      r_err <= w_drop;
      if (w_n_vld[0]) r_kvo <= {w_n_key[0], w_n_val[0]};
    end
  end

  assign kvo    = r_kvo;
  assign ovalid = r_vld[0];
  assign empty  = w_empty;
  assign full   = w_full;
  assign count  = r_cnt;
  assign err    = r_err;

endmodule

// File: tb/tb_ra_pq_p.sv
// Purpose: directed checks of ra_pq_p in min-first and max-first builds.
// Latency: results sampled 1 ns after the rising edge that takes each operation.
// Backpressure: none; one operation is driven per cycle.
module tb_ra_pq_p;

  logic        clk;
  logic        rst_n;
  logic        enq, deq, rep;
  logic [15:0] kvi;
  logic [15:0] kvo;
  logic        ovalid, empty, full, err;
  logic [2:0]  count;

  logic        m_enq, m_deq, m_rep;
  logic [15:0] m_kvi;
  logic [15:0] m_kvo;
  logic        m_ovalid, m_empty, m_full, m_err;
  logic [2:0]  m_count;

  int n_tests = 0;
  int n_fail  = 0;

  ra_pq_p #(.KEY_WIDTH(8), .VAL_WIDTH(8), .DEPTH(4), .MIN_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .replace(rep), .kvi(kvi),
    .kvo(kvo), .ovalid(ovalid), .empty(empty), .full(full), .count(count), .err(err)
  );

  ra_pq_p #(.KEY_WIDTH(8), .VAL_WIDTH(8), .DEPTH(4), .MIN_FIRST(0)) dut_max (
    .clk(clk), .rst_n(rst_n), .enq(m_enq), .deq(m_deq), .replace(m_rep), .kvi(m_kvi),
    .kvo(m_kvo), .ovalid(m_ovalid), .empty(m_empty), .full(m_full), .count(m_count), .err(m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [15:0] e_kvo, input logic [2:0] e_cnt,
                          input logic e_err);
    check({tag, ".kvo"},    32'(kvo),    32'(e_kvo));
    check({tag, ".count"},  32'(count),  32'(e_cnt));
    check({tag, ".ovalid"}, 32'(ovalid), 32'(e_cnt != 3'd0));
    check({tag, ".empty"},  32'(empty),  32'(e_cnt == 3'd0));
    check({tag, ".full"},   32'(full),   32'(e_cnt == 3'd4));
    check({tag, ".err"},    32'(err),    32'(e_err));
  endtask

  task automatic check_m(input string tag, input logic [15:0] e_kvo, input logic [2:0] e_cnt);
    check({tag, ".kvo"},    32'(m_kvo),    32'(e_kvo));
    check({tag, ".count"},  32'(m_count),  32'(e_cnt));
    check({tag, ".ovalid"}, 32'(m_ovalid), 32'(e_cnt != 3'd0));
    check({tag, ".err"},    32'(m_err),    32'd0);
  endtask

  task automatic op(input logic e, input logic d, input logic r, input logic [15:0] kv);
    @(negedge clk);
    enq = e; deq = d; rep = r; kvi = kv;
    @(posedge clk);
    #1;
    enq = 1'b0; deq = 1'b0; rep = 1'b0;
  endtask

  task automatic mop(input logic e, input logic d, input logic [15:0] kv);
    @(negedge clk);
    m_enq = e; m_deq = d; m_kvi = kv;
    @(posedge clk);
    #1;
    m_enq = 1'b0; m_deq = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    enq = 0; deq = 0; rep = 0; kvi = '0;
    m_enq = 0; m_deq = 0; m_rep = 0; m_kvi = '0;
    repeat (2) @(posedge clk);
    #1;
    check_st("reset", 16'h0000, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ordered inserts then drain: keys come out 8,9,10,11.
    op(1, 0, 0, 16'h080E); check_st("enq1", 16'h080E, 3'd1, 1'b0);
    op(1, 0, 0, 16'h0B0B); check_st("enq2", 16'h080E, 3'd2, 1'b0);
    op(1, 0, 0, 16'h0909); check_st("enq3", 16'h080E, 3'd3, 1'b0);
    op(1, 0, 0, 16'h0A0A); check_st("enq4", 16'h080E, 3'd4, 1'b0);
    op(0, 1, 0, 16'h0);    check_st("deq1", 16'h0909, 3'd3, 1'b0);
    op(0, 1, 0, 16'h0);    check_st("deq2", 16'h0A0A, 3'd2, 1'b0);
    op(0, 1, 0, 16'h0);    check_st("deq3", 16'h0B0B, 3'd1, 1'b0);
    op(0, 1, 0, 16'h0);    check_st("deq4", 16'h0B0B, 3'd0, 1'b0);

    // Refill, replace on full, overflow.
    op(1, 0, 0, 16'h080E);
    op(1, 0, 0, 16'h0B0B);
    op(1, 0, 0, 16'h0909);
    op(1, 0, 0, 16'h0A0A); check_st("refill", 16'h080E, 3'd4, 1'b0);
    op(0, 0, 1, 16'h0101); check_st("repl_full", 16'h0101, 3'd4, 1'b0);
    op(1, 0, 0, 16'h0505); check_st("ovf", 16'h0101, 3'd4, 1'b1);
    op(0, 0, 0, 16'h0);    check_st("ovf_clr", 16'h0101, 3'd4, 1'b0);
    op(0, 1, 0, 16'h0);    check_st("d1", 16'h0909, 3'd3, 1'b0);
    op(0, 1, 0, 16'h0);    check_st("d2", 16'h0A0A, 3'd2, 1'b0);
    op(0, 1, 0, 16'h0);    check_st("d3", 16'h0B0B, 3'd1, 1'b0);
    op(0, 1, 0, 16'h0);    check_st("d4", 16'h0B0B, 3'd0, 1'b0);

    // Underflow and replace on empty.
    op(0, 1, 0, 16'h0);    check_st("unf", 16'h0B0B, 3'd0, 1'b1);
    op(0, 0, 0, 16'h0);    check_st("unf_clr", 16'h0B0B, 3'd0, 1'b0);
    op(0, 0, 1, 16'h1717); check_st("repl_empty", 16'h1717, 3'd1, 1'b0);

    // enq+deq as replace, then FIFO order among equal keys.
    op(1, 0, 0, 16'h1119); check_st("enq17", 16'h1119, 3'd2, 1'b0);
    op(1, 1, 0, 16'h1103); check_st("enqdeq", 16'h1103, 3'd2, 1'b0);
    op(0, 1, 0, 16'h0);    check_st("ed_deq", 16'h1717, 3'd1, 1'b0);
    op(1, 0, 0, 16'h1707); check_st("tie_enq", 16'h1717, 3'd2, 1'b0);
    op(0, 1, 0, 16'h0);    check_st("tie_deq1", 16'h1707, 3'd1, 1'b0);
    op(0, 1, 0, 16'h0);    check_st("tie_deq2", 16'h1707, 3'd0, 1'b0);

    // Max-first build: largest key at head.
    check_m("m_idle", 16'h0000, 3'd0);
    mop(1, 0, 16'h0303); check_m("m_enq3",   16'h0303, 3'd1);
    mop(1, 0, 16'hC8C8); check_m("m_enq200", 16'hC8C8, 3'd2);
    mop(1, 0, 16'h3232); check_m("m_enq50",  16'hC8C8, 3'd3);
    mop(0, 1, 16'h0);    check_m("m_deq1",   16'h3232, 3'd2);
    mop(0, 1, 16'h0);    check_m("m_deq2",   16'h0303, 3'd1);
    mop(0, 1, 16'h0);    check_m("m_deq3",   16'h0303, 3'd0);

    // Asynchronous reset between edges with three entries stored.
    op(1, 0, 0, 16'h0505);
    op(1, 0, 0, 16'h0606);
    op(1, 0, 0, 16'h0707); check_st("pre_rst", 16'h0505, 3'd3, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_st("async_rst", 16'h0000, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    op(1, 0, 0, 16'h0404); check_st("post_rst", 16'h0404, 3'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
